// File: rtl/eeprom_stream_reader_if.sv
`timescale 1ns/1ps
// eeprom_stream_reader_if
// Bundles the three buses of the EEPROM stream reader:
//   avs_csr_*   : CSR slave port (read/write strobes, 2-bit word address, 16-bit data)
//   avm_m0_*    : byte-wide read master towards the EEPROM slave port
//   aso_out_*   : byte stream source with start/end of packet markers
//   ins_irq_irq : level interrupt
// Modport master is the reader's view (it masters the EEPROM bus and sources
// the stream). Modport slave is the surrounding system's view (CSR host,
// EEPROM slave and stream sink).
interface eeprom_stream_reader_if;
    logic        avs_csr_read;
    logic        avs_csr_write;
    logic [1:0]  avs_csr_address;
    logic [15:0] avs_csr_writedata;
    logic [15:0] avs_csr_readdata;
    logic        avm_m0_read;
    logic [15:0] avm_m0_address;
    logic [7:0]  avm_m0_readdata;
    logic        avm_m0_waitrequest;
    logic [7:0]  aso_out_data;
    logic        aso_out_valid;
    logic        aso_out_ready;
    logic        aso_out_startofpacket;
    logic        aso_out_endofpacket;
    logic        ins_irq_irq;

    modport master (
        input  avs_csr_read, avs_csr_write, avs_csr_address, avs_csr_writedata,
        output avs_csr_readdata,
        output avm_m0_read, avm_m0_address,
        input  avm_m0_readdata, avm_m0_waitrequest,
        output aso_out_data, aso_out_valid, aso_out_startofpacket, aso_out_endofpacket,
        input  aso_out_ready,
        output ins_irq_irq
    );

    modport slave (
        output avs_csr_read, avs_csr_write, avs_csr_address, avs_csr_writedata,
        input  avs_csr_readdata,
        input  avm_m0_read, avm_m0_address,
        output avm_m0_readdata, avm_m0_waitrequest,
        input  aso_out_data, aso_out_valid, aso_out_startofpacket, aso_out_endofpacket,
        output aso_out_ready,
        input  ins_irq_irq
    );
endinterface

// File: rtl/eeprom_stream_reader.sv
`timescale 1ns/1ps
// eeprom_stream_reader
// Reads LENGTH bytes from an EEPROM slave starting at START_ADDR, one
// outstanding byte read at a time, and forwards each byte on a stream port
// with start/end of packet markers. Software programs and monitors the
// transfer through four CSR words (0 ctrl/status, 1 START_ADDR, 2 LENGTH,
// 3 REMAINING). A read stalled for TIMEOUT_CYCLES cycles is abandoned.
// Ports:
//   csi_clk   : clock, all logic on its rising edge
//   rsi_reset : asynchronous active-low reset
//   bus       : CSR slave, EEPROM read master, byte stream source, irq
module eeprom_stream_reader #(
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
    input  logic                          csi_clk,
    input  logic                          rsi_reset,
    eeprom_stream_reader_if.master        bus
);
    localparam int unsigned STALL_W = (TIMEOUT_CYCLES > 32'd1) ? $clog2(TIMEOUT_CYCLES) : 32'd1;
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(TIMEOUT_CYCLES - 32'd1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_PUSH = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    state_t             state_r;
    logic [15:0]        startAddr_r;
    logic [15:0]        length_r;
    logic [15:0]        remaining_r;
    logic [15:0]        addrCnt_r;
    logic [STALL_W-1:0] stallCnt_r;
    logic               irqEn_r;
    logic               done_r;
    logic               error_r;
    logic               busy_r;
    logic               firstByte_r;
    logic               abortPend_r;
    logic               read_r;
    logic [7:0]         data_r;
    logic               valid_r;
    logic               sop_r;
    logic               eop_r;
    logic [15:0]        csrRdata_r;

    logic               ctrlWr_s;
    logic               startReq_s;
    logic               abortReq_s;
    logic               clrDone_s;
    logic               clrErr_s;
    logic [15:0]        csrMux_s;

    assign ctrlWr_s   = bus.avs_csr_write & (bus.avs_csr_address == 2'd0);
    assign startReq_s = ctrlWr_s & bus.avs_csr_writedata[0];
    assign abortReq_s = ctrlWr_s & bus.avs_csr_writedata[1];
    assign clrDone_s  = ctrlWr_s & bus.avs_csr_writedata[3];
    assign clrErr_s   = ctrlWr_s & bus.avs_csr_writedata[4];

    // CSR read data selection
    always_comb begin
        csrMux_s = 16'd0;
        case (bus.avs_csr_address)
            2'd0:    csrMux_s = {11'd0, error_r, done_r, irqEn_r, 1'b0, busy_r};
            2'd1:    csrMux_s = startAddr_r;
            2'd2:    csrMux_s = length_r;
            2'd3:    csrMux_s = remaining_r;
            default: csrMux_s = 16'd0;
        endcase
    end

    // Registered CSR read data, zero whenever no read was strobed
    always_ff @(posedge csi_clk or negedge rsi_reset) begin
        if (!rsi_reset) begin
            csrRdata_r <= 16'd0;
        end else if (bus.avs_csr_read) begin
            csrRdata_r <= csrMux_s;
        end else begin
            csrRdata_r <= 16'd0;
        end
    end

    // Configuration registers; address and length are frozen while busy
    always_ff @(posedge csi_clk or negedge rsi_reset) begin
        if (!rsi_reset) begin
            startAddr_r <= 16'd0;
            length_r    <= 16'd0;
            irqEn_r     <= 1'b0;
        end else if (bus.avs_csr_write) begin
            case (bus.avs_csr_address)
                2'd0:    irqEn_r <= bus.avs_csr_writedata[2];
                2'd1:    if (!busy_r) startAddr_r <= bus.avs_csr_writedata;
                2'd2:    if (!busy_r) length_r <= bus.avs_csr_writedata;
                default: irqEn_r <= irqEn_r;
            endcase
        end
    end

    // Transfer FSM with its datapath and registered bus outputs
    always_ff @(posedge csi_clk or negedge rsi_reset) begin
        if (!rsi_reset) begin
            state_r     <= ST_IDLE;
            remaining_r <= 16'd0;
            addrCnt_r   <= 16'd0;
            stallCnt_r  <= '0;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
            busy_r      <= 1'b0;
            firstByte_r <= 1'b0;
            abortPend_r <= 1'b0;
            read_r      <= 1'b0;
            data_r      <= 8'd0;
            valid_r     <= 1'b0;
            sop_r       <= 1'b0;
            eop_r       <= 1'b0;
        end else begin
            // Software clears first; a hardware set later in this block wins.
            if (clrDone_s) done_r <= 1'b0;
            if (clrErr_s)  error_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    abortPend_r <= 1'b0;
                    if (startReq_s) begin
                        addrCnt_r   <= startAddr_r;
                        remaining_r <= length_r;
                        done_r      <= 1'b0;
                        error_r     <= 1'b0;
                        firstByte_r <= 1'b1;
                        stallCnt_r  <= '0;
                        if (length_r == 16'd0) begin
                            state_r <= ST_DONE;
                        end else begin
                            state_r <= ST_REQ;
                            busy_r  <= 1'b1;
                            read_r  <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (!bus.avm_m0_waitrequest) begin
                        read_r     <= 1'b0;
                        stallCnt_r <= '0;
                        // An abort can only land once the slave has accepted the read.
                        if (abortPend_r || abortReq_s) begin
                            state_r <= ST_ERR;
                        end else begin
                            data_r  <= bus.avm_m0_readdata;
                            valid_r <= 1'b1;
                            sop_r   <= firstByte_r;
                            eop_r   <= (remaining_r == 16'd1);
                            state_r <= ST_PUSH;
                        end
                    end else if (stallCnt_r == STALL_MAX) begin
                        read_r     <= 1'b0;
                        stallCnt_r <= '0;
                        state_r    <= ST_ERR;
                    end else begin
                        stallCnt_r  <= stallCnt_r + STALL_W'(1);
                        abortPend_r <= abortPend_r | abortReq_s;
                    end
                end
                ST_PUSH: begin
                    if (bus.aso_out_ready) begin
                        // The beat is delivered even when an abort arrives with it.
                        valid_r     <= 1'b0;
                        sop_r       <= 1'b0;
                        eop_r       <= 1'b0;
                        firstByte_r <= 1'b0;
                        remaining_r <= remaining_r - 16'd1;
                        addrCnt_r   <= addrCnt_r + 16'd1;
                        if (abortReq_s) begin
                            state_r <= ST_ERR;
                        end else if (remaining_r == 16'd1) begin
                            state_r <= ST_DONE;
                        end else begin
                            state_r    <= ST_REQ;
                            read_r     <= 1'b1;
                            stallCnt_r <= '0;
                        end
                    end else if (abortReq_s) begin
                        valid_r <= 1'b0;
                        sop_r   <= 1'b0;
                        eop_r   <= 1'b0;
                        state_r <= ST_ERR;
                    end
                end
                ST_DONE: begin
                    done_r      <= 1'b1;
                    busy_r      <= 1'b0;
                    abortPend_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
                ST_ERR: begin
                    error_r     <= 1'b1;
                    busy_r      <= 1'b0;
                    abortPend_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    read_r  <= 1'b0;
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.avs_csr_readdata      = csrRdata_r;
    assign bus.avm_m0_read           = read_r;
    assign bus.avm_m0_address        = addrCnt_r;
    assign bus.aso_out_data          = data_r;
    assign bus.aso_out_valid         = valid_r;
    assign bus.aso_out_startofpacket = sop_r;
    assign bus.aso_out_endofpacket   = eop_r;
    assign bus.ins_irq_irq           = irqEn_r & (done_r | error_r);
endmodule

// File: tb/tb_eeprom_stream_reader.sv
`timescale 1ns/1ps
// tb_eeprom_stream_reader
// Two readers run from the same stimulus: dutM (stall limit 64) for normal
// transfers and dutT (stall limit 16) for the timeout case; selT picks which
// one is observed. The EEPROM is a fixed byte pattern of the address.
module tb_eeprom_stream_reader;
    logic csi_clk = 1'b0;
    logic rstN;
    always #5 csi_clk = ~csi_clk;

    function automatic logic [7:0] memByte(input logic [15:0] a);
        return a[7:0] ^ {a[12:8], a[15:13]} ^ 8'h5A;
    endfunction

    eeprom_stream_reader_if busM();
    eeprom_stream_reader_if busT();

    eeprom_stream_reader #(.TIMEOUT_CYCLES(64)) dutM (.csi_clk(csi_clk), .rsi_reset(rstN), .bus(busM));
    eeprom_stream_reader #(.TIMEOUT_CYCLES(16)) dutT (.csi_clk(csi_clk), .rsi_reset(rstN), .bus(busT));

    logic        csrRead, csrWrite, waitReq, outReady;
    logic [1:0]  csrAddr;
    logic [15:0] csrWdata;

    assign busM.avs_csr_read      = csrRead;
    assign busM.avs_csr_write     = csrWrite;
    assign busM.avs_csr_address   = csrAddr;
    assign busM.avs_csr_writedata = csrWdata;
    assign busM.avm_m0_waitrequest = waitReq;
    assign busM.aso_out_ready     = outReady;
    assign busM.avm_m0_readdata   = waitReq ? 8'hEE : memByte(busM.avm_m0_address);
    assign busT.avs_csr_read      = csrRead;
    assign busT.avs_csr_write     = csrWrite;
    assign busT.avs_csr_address   = csrAddr;
    assign busT.avs_csr_writedata = csrWdata;
    assign busT.avm_m0_waitrequest = waitReq;
    assign busT.aso_out_ready     = outReady;
    assign busT.avm_m0_readdata   = waitReq ? 8'hEE : memByte(busT.avm_m0_address);

    logic        selT = 1'b0;
    logic [15:0] oRdata, oAddr;
    logic [7:0]  oData;
    logic        oRead, oValid, oSop, oEop, oIrq;
    always_comb begin
        oRdata = selT ? busT.avs_csr_readdata      : busM.avs_csr_readdata;
        oAddr  = selT ? busT.avm_m0_address        : busM.avm_m0_address;
        oRead  = selT ? busT.avm_m0_read           : busM.avm_m0_read;
        oData  = selT ? busT.aso_out_data          : busM.aso_out_data;
        oValid = selT ? busT.aso_out_valid         : busM.aso_out_valid;
        oSop   = selT ? busT.aso_out_startofpacket : busM.aso_out_startofpacket;
        oEop   = selT ? busT.aso_out_endofpacket   : busM.aso_out_endofpacket;
        oIrq   = selT ? busT.ins_irq_irq           : busM.ins_irq_irq;
    end

    int nCmp = 0;
    int nFail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave/sink behaviour: random stalls plus forced holds for directed cases.
    int   waitPct = 0;
    int   readyPct = 100;
    logic forceWait = 1'b0;
    logic forceNotReady = 1'b0;
    always @(posedge csi_clk) begin
        #2;
        waitReq  = forceWait || (int'($urandom_range(99)) < waitPct);
        outReady = !forceNotReady && (int'($urandom_range(99)) < readyPct);
    end

    // Monitor: record accepted reads and delivered beats, check handshake rules.
    logic [15:0] gotAddr[$];
    logic [9:0]  gotBeat[$];
    logic        pRead = 1'b0, pWait = 1'b0, pValid = 1'b0, pReady = 1'b0;
    logic [15:0] pAddr = 16'd0;
    logic [9:0]  pBeat = 10'd0;
    always @(negedge csi_clk) begin
        if (rstN) begin
            check("read_with_valid", {31'd0, oRead & oValid}, 32'd0);
            if (pRead && pWait && oRead) check("addr_stable", oAddr, pAddr);
            if (pValid && !pReady && oValid) check("beat_stable", {oSop, oEop, oData}, pBeat);
            if (oRead && !waitReq) gotAddr.push_back(oAddr);
            if (oValid && outReady) gotBeat.push_back({oSop, oEop, oData});
            pRead = oRead; pWait = waitReq; pValid = oValid; pReady = outReady;
            pAddr = oAddr; pBeat = {oSop, oEop, oData};
        end else begin
            pRead = 1'b0; pWait = 1'b0; pValid = 1'b0; pReady = 1'b0;
        end
    end

    task automatic tick();
        @(posedge csi_clk);
        #1;
    endtask

    task automatic csrWr(input logic [1:0] a, input logic [15:0] d);
        csrWrite = 1'b1; csrAddr = a; csrWdata = d;
        tick();
        csrWrite = 1'b0;
    endtask

    task automatic csrRd(input logic [1:0] a, output logic [15:0] d);
        csrRead = 1'b1; csrAddr = a;
        tick();
        csrRead = 1'b0;
        d = oRdata;
    endtask

    task automatic waitIdle(input string tag, output logic [15:0] st);
        int n = 0;
        csrRd(2'd0, st);
        while (!(st[3] | st[4]) && n < 3000) begin
            csrRd(2'd0, st);
            n++;
        end
        check({tag, "_finish_in_time"}, {31'd0, n < 3000}, 32'd1);
    endtask

    task automatic waitValid(input string tag);
        int n = 0;
        while (!oValid && n < 200) begin
            tick();
            n++;
        end
        check(tag, {31'd0, oValid}, 32'd1);
    endtask

    task automatic doReset();
        rstN = 1'b0;
        repeat (2) tick();
        rstN = 1'b1;
        tick();
    endtask

    // Reference: bytes start..start+len-1 (mod 2^16) in order, sop first, eop last.
    task automatic checkStream(input logic [15:0] s, input int len, input int nBeats, input string tag);
        logic [15:0] a;
        logic [9:0]  expBeat;
        check({tag, "_n_reads"}, gotAddr.size(), nBeats);
        check({tag, "_n_beats"}, gotBeat.size(), nBeats);
        for (int i = 0; i < nBeats; i++) begin
            a = s + 16'(i);
            expBeat = {(i == 0), (i == len - 1), memByte(a)};
            if (i < gotAddr.size()) check($sformatf("%s_addr%0d", tag, i), gotAddr[i], a);
            if (i < gotBeat.size()) check($sformatf("%s_beat%0d", tag, i), gotBeat[i], expBeat);
        end
    endtask

    typedef struct {
        logic [15:0] startAddr;
        logic [15:0] len;
        int          waitPct;
        int          readyPct;
        int          expBeats;
        logic        expDone;
    } vec_t;
    vec_t vecs[8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] st, d;
        int n;
        vecs[0] = '{16'h0010, 16'd4, 0, 100, 4, 1'b1};
        vecs[1] = '{16'hFFFE, 16'd3, 30, 70, 3, 1'b1};
        vecs[2] = '{16'h0000, 16'd0, 0, 100, 0, 1'b1};
        vecs[3] = '{16'h1234, 16'd1, 50, 50, 1, 1'b1};
        for (int i = 4; i < 8; i++) begin
            int l;
            l = int'($urandom_range(12, 1));
            vecs[i] = '{16'($urandom), 16'(l), int'($urandom_range(60, 0)), int'($urandom_range(100, 30)), l, 1'b1};
        end

        csrRead = 1'b0; csrWrite = 1'b0; csrAddr = 2'd0; csrWdata = 16'd0;
        waitReq = 1'b0; outReady = 1'b0;
        rstN = 1'b0;
        repeat (3) tick();
        rstN = 1'b1;
        tick();

        check("reset_outputs", {3'd0, oRead, oValid, oSop, oEop, oIrq, oData, oAddr}, 32'd0);
        csrRd(2'd0, d); check("reset_status", d, 16'd0);
        csrRd(2'd1, d); check("reset_start", d, 16'd0);
        csrRd(2'd2, d); check("reset_length", d, 16'd0);
        csrRd(2'd3, d); check("reset_remaining", d, 16'd0);

        for (int i = 0; i < 8; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            waitPct = vecs[i].waitPct; readyPct = vecs[i].readyPct;
            gotAddr.delete(); gotBeat.delete();
            csrWr(2'd1, vecs[i].startAddr);
            csrWr(2'd2, vecs[i].len);
            csrWr(2'd0, 16'h0001);
            waitIdle(tag, st);
            check({tag, "_done"}, {31'd0, st[3]}, {31'd0, vecs[i].expDone});
            check({tag, "_error_busy"}, {30'd0, st[4], st[0]}, 32'd0);
            csrRd(2'd3, d); check({tag, "_remaining"}, d, 16'd0);
            checkStream(vecs[i].startAddr, int'(vecs[i].len), vecs[i].expBeats, tag);
        end
        waitPct = 0; readyPct = 100;

        // Read data returns to zero the cycle after a read.
        csrWr(2'd1, 16'hBEEF);
        csrRd(2'd1, d); check("start_readback", d, 16'hBEEF);
        tick(); check("rdata_zero_after_read", oRdata, 16'd0);

        // Zero-length start; done W1C collides with the hardware set.
        gotAddr.delete(); gotBeat.delete();
        csrWr(2'd2, 16'd0);
        csrWr(2'd0, 16'h0005);
        csrWr(2'd0, 16'h000C);
        csrRd(2'd0, d); check("len0_set_wins_status", d, 16'h000C);
        check("len0_irq", {31'd0, oIrq}, 32'd1);
        check("len0_no_traffic", gotAddr.size() + gotBeat.size(), 32'd0);
        csrWr(2'd0, 16'h000C);
        csrRd(2'd0, d); check("done_w1c_status", d, 16'h0004);
        check("done_w1c_irq", {31'd0, oIrq}, 32'd0);

        // Long slave stall then long sink backpressure.
        gotAddr.delete(); gotBeat.delete();
        forceWait = 1'b1; forceNotReady = 1'b1;
        csrWr(2'd1, 16'h0200); csrWr(2'd2, 16'd2); csrWr(2'd0, 16'h0001);
        repeat (50) tick();
        check("stall_read_held", {31'd0, oRead}, 32'd1);
        csrWr(2'd2, 16'd9);
        csrRd(2'd2, d); check("length_frozen_busy", d, 16'd2);
        forceWait = 1'b0;
        waitValid("stall_first_valid");
        repeat (20) tick();
        check("backpressure_valid_held", {31'd0, oValid}, 32'd1);
        check("backpressure_no_beat", gotBeat.size(), 32'd0);
        forceNotReady = 1'b0;
        waitIdle("stall", st);
        check("stall_status", st, 16'h0008);
        checkStream(16'h0200, 2, 2, "stall");

        // Reset asserted while a read is pending.
        doReset();
        forceWait = 1'b1;
        csrWr(2'd1, 16'h0300); csrWr(2'd2, 16'd3); csrWr(2'd0, 16'h0001);
        tick();
        check("mid_req_read", {31'd0, oRead}, 32'd1);
        #2 rstN = 1'b0;
        #1 check("mid_req_reset_outputs", {3'd0, oRead, oValid, oSop, oEop, oIrq, oData, oAddr}, 32'd0);
        check("mid_req_reset_rdata", oRdata, 16'd0);
        tick();
        rstN = 1'b1;
        repeat (3) tick();
        check("after_reset_idle", {30'd0, oRead, oValid}, 32'd0);
        csrRd(2'd0, d); check("after_reset_status", d, 16'd0);
        csrRd(2'd1, d); check("after_reset_start", d, 16'd0);

        // Timeout on the reader with a 16-cycle stall limit.
        doReset();
        selT = 1'b1;
        gotAddr.delete(); gotBeat.delete();
        csrWr(2'd1, 16'h0400); csrWr(2'd2, 16'd3); csrWr(2'd0, 16'h0005);
        n = 0;
        while (oRead && n < 100) begin
            n++;
            tick();
        end
        check("timeout_read_cycles", n, 32'd16);
        forceWait = 1'b0;
        waitIdle("timeout", st);
        check("timeout_status", st, 16'h0014);
        check("timeout_irq", {31'd0, oIrq}, 32'd1);
        csrRd(2'd3, d); check("timeout_remaining", d, 16'd3);
        check("timeout_no_beat", gotBeat.size(), 32'd0);
        csrWr(2'd0, 16'h0014);
        csrRd(2'd0, d); check("error_w1c_status", d, 16'h0004);
        check("error_w1c_irq", {31'd0, oIrq}, 32'd0);

        // Abort while byte 2 of 5 is waiting on the sink.
        selT = 1'b0;
        doReset();
        gotAddr.delete(); gotBeat.delete();
        forceNotReady = 1'b1;
        csrWr(2'd1, 16'h0500); csrWr(2'd2, 16'd5); csrWr(2'd0, 16'h0001);
        waitValid("abort_byte1_valid");
        forceNotReady = 1'b0;
        tick();
        forceNotReady = 1'b1;
        tick();
        waitValid("abort_byte2_valid");
        csrWr(2'd0, 16'h0002);
        check("abort_valid_dropped", {31'd0, oValid}, 32'd0);
        waitIdle("abort", st);
        check("abort_status", st, 16'h0010);
        csrRd(2'd3, d); check("abort_remaining", d, 16'd4);
        check("abort_n_beats", gotBeat.size(), 32'd1);
        check("abort_n_reads", gotAddr.size(), 32'd2);
        if (gotBeat.size() > 0) check("abort_beat0", gotBeat[0], {2'b10, memByte(16'h0500)});
        forceNotReady = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end
endmodule

// File: doc/eeprom_stream_reader.md
EEPROM_STREAM_READER -- requirements
Module: eeprom_stream_reader

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 2_000_000, maximum cycles one master read may stall on waitrequest before it is abandoned.
REQ-002 csi_clk  input  1  single clock; all logic on its rising edge.
REQ-003 rsi_reset  input  1  reset, asynchronous assert, active-low.
REQ-004 avs_csr_read  input  1  CSR read strobe.
REQ-005 avs_csr_write  input  1  CSR write strobe.
REQ-006 avs_csr_address  input  2  CSR word select.
REQ-007 avs_csr_writedata  input  16  CSR write data.
REQ-008 avs_csr_readdata  output  16  CSR read data.
REQ-009 avm_m0_read  output  1  byte read request to the EEPROM slave port.
REQ-010 avm_m0_address  output  16  EEPROM byte address.
REQ-011 avm_m0_readdata  input  8  EEPROM read data.
REQ-012 avm_m0_waitrequest  input  1  slave stall.
REQ-013 aso_out_data  output  8  streamed byte.
REQ-014 aso_out_valid  output  1  byte valid.
REQ-015 aso_out_ready  input  1  sink accepts.
REQ-016 aso_out_startofpacket  output  1  first byte of a transfer.
REQ-017 aso_out_endofpacket  output  1  last byte of a transfer.
REQ-018 ins_irq_irq  output  1  level interrupt.

Function
REQ-019 CSR map: 0 control/status, 1 START_ADDR, 2 LENGTH (bytes), 3 REMAINING (read-only).
REQ-020 Ctrl write bits: 0 start, 1 abort, 2 irq_en (stored), 3 done W1C, 4 error W1C.
REQ-021 Status read: bit0 busy, bit2 irq_en, bit3 done, bit4 error, others 0.
REQ-022 CSR readdata is registered (1-cycle latency) and is 0 in any cycle after which avs_csr_read was low.
REQ-023 Writes to START_ADDR/LENGTH while busy are ignored; start while busy is ignored.
REQ-024 ins_irq_irq = irq_en & (done | error), combinational from registers.
REQ-025 FSM states IDLE, REQ, PUSH, DONE, ERR.
REQ-026 IDLE: start with LENGTH!=0 -> REQ next cycle, busy=1, addr counter=START_ADDR, REMAINING=LENGTH, done/error cleared.
REQ-027 Start with LENGTH=0 -> DONE directly, no master read, no stream byte.
REQ-028 REQ: avm_m0_read=1, address held stable; in a cycle with waitrequest=0 capture readdata into aso_out_data, deassert read, go PUSH.
REQ-029 PUSH: aso_out_valid=1, data/sop/eop held stable until aso_out_ready=1; a beat transfers when valid&ready.
REQ-030 sop=1 only on the first byte; eop=1 only when REMAINING==1.
REQ-031 On transfer: REMAINING-=1, address+=1 mod 2^16 (0xFFFF wraps to 0x0000); REMAINING 0 -> DONE else REQ next cycle.
REQ-032 avm_m0_read and aso_out_valid are never high in the same cycle; at most one outstanding read.
REQ-033 Stall counter counts REQ cycles with waitrequest=1; reaching TIMEOUT_CYCLES -> ERR, read deasserted, counter cleared on each new read.
REQ-034 Abort while busy: REQ -> ERR only once waitrequest=0 (accepted read data discarded); PUSH -> ERR immediately, valid dropped.
REQ-035 DONE: set done, busy=0, -> IDLE. ERR: set error, busy=0, -> IDLE; REMAINING keeps the untransferred count.
REQ-036 Simultaneous W1C of done and hardware setting done in the same cycle: set wins.

Reset
REQ-037 rsi_reset low asynchronously forces: state IDLE, all outputs 0, START_ADDR=0, LENGTH=0, REMAINING=0, irq_en=0, done=0, error=0, stall counter 0.
REQ-038 Reset deassertion mid-transfer starts cleanly in IDLE; no residual read or valid.

Verification
REQ-039 START_ADDR=0x0010, LENGTH=4, ready=1, zero-wait slave -> bytes from 0x10..0x13 in order, sop on first, eop on fourth, done=1, REMAINING=0.
REQ-040 START_ADDR=0xFFFE, LENGTH=3 -> addresses 0xFFFE, 0xFFFF, 0x0000 issued.
REQ-041 Slave holds waitrequest 50 cycles, sink holds ready low 20 cycles -> address/data/valid stable throughout, no byte lost or duplicated.
REQ-042 TIMEOUT_CYCLES=16, waitrequest stuck high -> read drops after 16 stall cycles, error=1, irq high when irq_en=1.
REQ-043 LENGTH=0 start -> done=1 next cycle, no avm_m0_read, no valid.
REQ-044 Abort during PUSH of byte 2 of 5 -> valid drops next cycle, error=1, REMAINING=4; reset low mid-REQ -> all outputs 0 immediately.
